prefix_decoder: RTL and testbench
=================================

# prefix_decoder

Upstream stage of the segment-override logic: consumes instruction bytes from the show-ahead prefetch FIFO, absorbs 8086 prefix bytes (segment, REP/REPNE, optional LOCK), and presents the first non-prefix byte as the opcode with a valid/ready handshake. Prefix state persists for the whole instruction so the microcode sequencer and the segment-override stage can read it. The state clears at instruction end or on a flush.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fifo_rd_data  in  8  head byte of prefetch FIFO; valid whenever !fifo_empty
- fifo_empty  in  1  FIFO has no byte
- fifo_rd_en  out  1  pop head byte this cycle
- flush  in  1  discard everything (branch/interrupt); synchronous
- next_instruction  in  1  microcode finished current instruction
- opcode  out  8  registered opcode byte
- opcode_valid  out  1  opcode presented to sequencer
- opcode_ready  in  1  sequencer accepts opcode
- segment_override  out  1  a segment prefix was seen this instruction
- segment_sel  out  2  override segment: ES=0, CS=1, SS=2, DS=3 (byte bits [4:3])
- rep  out  1  F3 prefix active
- repne  out  1  F2 prefix active
- lock  out  1  F0 prefix active (only with LOCK_PREFIX_EN)
- prefix_count  out  4  prefixes absorbed, saturating at 15

## Operation
- States: FETCH, PRESENT, EXEC.
- FETCH:
  - fifo_rd_en = !fifo_empty.
  - On a popped byte:
    - 26/2E/36/3E: segment_override <= 1, segment_sel <= byte[4:3], count++.
    - F3: rep <= 1, repne <= 0, count++.
    - F2: repne <= 1, rep <= 0, count++.
    - F0 (macro on): lock <= 1, count++.
    - Any other byte: opcode <= byte, go to PRESENT.
  - Repeated segment prefixes: last wins. Repeated REP prefixes: last wins.
- PRESENT:
  - opcode_valid = 1, fifo_rd_en = 0.
  - On opcode_ready: go to EXEC.
  - opcode and opcode_valid stay stable until accepted.
- EXEC:
  - fifo_rd_en = 0, opcode_valid = 0.
  - Prefix outputs are held.
  - On next_instruction: clear all prefix state and count, go to FETCH.
- next_instruction in FETCH or PRESENT: ignored.
- flush in any state:
  - Go to FETCH, clear prefix state, count, and opcode_valid.
  - fifo_rd_en = 0 that cycle.
  - flush has priority over every other event.
- prefix_count saturates at 15. Further prefixes are still decoded.

## Timing
- Reset values: state FETCH, opcode 00, opcode_valid 0, segment_override 0, segment_sel 00, rep 0, repne 0, lock 0, prefix_count 0. fifo_rd_en follows combinationally (= !fifo_empty).
- fifo_rd_en is combinational from state and fifo_empty. The byte is consumed at the same clock edge.
- Each prefix costs one cycle. Its flags are visible the cycle after the pop.
- Opcode latency: opcode_valid rises the cycle after the opcode byte is popped. With n prefixes and a non-empty FIFO, this is n+1 cycles after entering FETCH.
- Prefix flags are stable before, and throughout, opcode_valid.
- opcode_valid & opcode_ready in the same cycle transfers at that edge.
- Back-to-back instructions: next_instruction in EXEC allows a pop on the following cycle.
- FIFO empty in FETCH: waits indefinitely; accumulated prefixes are kept.

## Configuration
- LOCK_PREFIX_EN:
  - Defined: F0 is a prefix, sets lock, and counts.
  - Undefined:
    - F0 is treated as an opcode byte.
    - The lock port remains and is tied to 0.

## Test plan
- Plain opcode: FIFO 8B, sequencer ready -> fifo_rd_en one cycle. Next cycle: opcode=8B, opcode_valid=1, all flags 0, count 0.
- Segment last-wins: bytes 26, 3E, 8B -> segment_override=1, segment_sel=3, count=2, opcode=8B. After next_instruction in EXEC, all flags clear.
- REP swap and stall:
  - Stimulus: bytes F2, F3, A4, with opcode_ready held low 5 cycles.
  - Response: rep=1, repne=0, count=2.
  - opcode_valid is held 5 cycles with opcode=A4, and no pops occur.
- Flush mid-prefix: pop 2E, then flush with F3 at the FIFO head -> F3 not popped that cycle, all prefix state cleared. The next cycle pops F3 fresh.
- Saturation: 17 consecutive 36 bytes then 90 -> prefix_count=15, segment_sel=2, opcode=90.
- Macro check: F0, 90 -> with LOCK_PREFIX_EN, lock=1 and opcode=90. Without it, opcode=F0, lock=0, and 90 stays in the FIFO.

Source files
------------

// File: rtl/prefix_decoder_if.sv
// rtl/prefix_decoder_if.sv - Prefetch FIFO, opcode handshake and prefix-state bundle for prefix_decoder
//
// Signals:
//   fifo_rd_data, fifo_empty, fifo_rd_en : show-ahead prefetch FIFO read port
//   flush, next_instruction              : pipeline control from the sequencer
//   opcode, opcode_valid, opcode_ready   : opcode handshake to the sequencer
//   segment_override, segment_sel, rep,
//   repne, lock, prefix_count            : prefix state held for the instruction
// Modports: master = decoder side, slave = FIFO/sequencer side.

interface prefix_decoder_if;
    logic [7:0] fifo_rd_data;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic       flush;
    logic       next_instruction;
    logic [7:0] opcode;
    logic       opcode_valid;
    logic       opcode_ready;
    logic       segment_override;
    logic [1:0] segment_sel;
    logic       rep;
    logic       repne;
    logic       lock;
    logic [3:0] prefix_count;

    modport master (
        input  fifo_rd_data, fifo_empty, flush, next_instruction, opcode_ready,
        output fifo_rd_en, opcode, opcode_valid, segment_override, segment_sel,
               rep, repne, lock, prefix_count
    );

    modport slave (
        output fifo_rd_data, fifo_empty, flush, next_instruction, opcode_ready,
        input  fifo_rd_en, opcode, opcode_valid, segment_override, segment_sel,
               rep, repne, lock, prefix_count
    );
endinterface

// File: rtl/prefix_decoder.sv
// rtl/prefix_decoder.sv - 8086 prefix absorber presenting the first non-prefix byte as the opcode
//
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : prefix_decoder_if.master (FIFO read, flush/next_instruction,
//           opcode handshake, prefix state outputs)
// Build option: define LOCK_PREFIX_EN to treat F0 as the LOCK prefix;
// otherwise F0 is an ordinary opcode and lock is tied low.

module prefix_decoder (
    input  logic              clk,
    input  logic              reset,
    prefix_decoder_if.master  bus
);
    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] PRESENT = 2'd1;
    localparam logic [1:0] EXEC    = 2'd2;

    logic [1:0] state;
    logic [7:0] opcode_q;
    logic       opcode_valid_q;
    logic       seg_q;
    logic [1:0] seg_sel_q;
    logic       rep_q;
    logic       repne_q;
    logic [3:0] count_q;

    logic [7:0] head;
    logic       pop;
    logic       is_seg;
    logic       is_rep;
    logic       is_repne;
    logic       is_lock;
    logic       is_prefix;
    logic [3:0] count_inc;

    assign head = bus.fifo_rd_data;

    // 26/2E/36/3E share the pattern 001s_s110; ss is the segment number.
    assign is_seg   = (head[7:5] == 3'b001) && (head[2:0] == 3'b110);
    assign is_rep   = (head == 8'hF3);
    assign is_repne = (head == 8'hF2);
`ifdef LOCK_PREFIX_EN
    assign is_lock  = (head == 8'hF0);
`else
    assign is_lock  = 1'b0;
`endif
    assign is_prefix = is_seg | is_rep | is_repne | is_lock;
    assign count_inc = (count_q == 4'hF) ? count_q : count_q + 4'd1;

    // A flush cycle must not consume the head byte: it belongs to the
    // restarted stream.
    assign bus.fifo_rd_en = (state == FETCH) && !bus.fifo_empty && !bus.flush;
    assign pop = bus.fifo_rd_en;

    assign bus.opcode           = opcode_q;
    assign bus.opcode_valid     = opcode_valid_q;
    assign bus.segment_override = seg_q;
    assign bus.segment_sel      = seg_sel_q;
    assign bus.rep              = rep_q;
    assign bus.repne            = repne_q;
    assign bus.prefix_count     = count_q;

`ifdef LOCK_PREFIX_EN
    logic lock_q;
    assign bus.lock = lock_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q <= 1'b0;
        end else if (bus.flush) begin
            lock_q <= 1'b0;
        end else if (state == EXEC && bus.next_instruction) begin
            lock_q <= 1'b0;
        end else if (pop && is_lock) begin
            lock_q <= 1'b1;
        end
    end
`else
    assign bus.lock = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= FETCH;
            opcode_q       <= 8'h00;
            opcode_valid_q <= 1'b0;
            seg_q          <= 1'b0;
            seg_sel_q      <= 2'd0;
            rep_q          <= 1'b0;
            repne_q        <= 1'b0;
            count_q        <= 4'd0;
        end else if (bus.flush) begin
            state          <= FETCH;
            opcode_valid_q <= 1'b0;
            seg_q          <= 1'b0;
            seg_sel_q      <= 2'd0;
            rep_q          <= 1'b0;
            repne_q        <= 1'b0;
            count_q        <= 4'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (pop) begin
                        if (is_prefix) begin
                            count_q <= count_inc;
                        end
                        if (is_seg) begin
                            seg_q     <= 1'b1;
                            seg_sel_q <= head[4:3];
                        end
                        if (is_rep) begin
                            rep_q   <= 1'b1;
                            repne_q <= 1'b0;
                        end
                        if (is_repne) begin
                            repne_q <= 1'b1;
                            rep_q   <= 1'b0;
                        end
                        if (!is_prefix) begin
                            opcode_q       <= head;
                            opcode_valid_q <= 1'b1;
                            state          <= PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    if (bus.opcode_ready) begin
                        opcode_valid_q <= 1'b0;
                        state          <= EXEC;
                    end
                end
                EXEC: begin
                    if (bus.next_instruction) begin
                        seg_q     <= 1'b0;
                        seg_sel_q <= 2'd0;
                        rep_q     <= 1'b0;
                        repne_q   <= 1'b0;
                        count_q   <= 4'd0;
                        state     <= FETCH;
                    end
                end
                default: begin
                    opcode_valid_q <= 1'b0;
                    state          <= FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prefix_decoder.sv
// tb/tb_prefix_decoder.sv - Self-checking bench for prefix_decoder

module tb_prefix_decoder;
    typedef struct {
        logic [7:0] op;
        logic       seg;
        logic [1:0] sel;
        logic       rep;
        logic       repne;
        logic       lock;
        logic [3:0] cnt;
        int         lat;
        int         left;
    } exp_t;

    typedef struct {
        logic [159:0] bytes;
        int           n;
        exp_t         e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    prefix_decoder_if bus();
    prefix_decoder dut (.clk(clk), .reset(reset), .bus(bus));

    logic [7:0] fifo_q[$];
    exp_t       sb[$];
    vec_t       vecs[7];
    int         tests = 0;
    int         fails = 0;

    function automatic exp_t mk(logic [7:0] op, logic seg, logic [1:0] sel, logic rep,
                                logic repne, logic lock, logic [3:0] cnt, int lat, int left);
        exp_t e;
        e.op = op; e.seg = seg; e.sel = sel; e.rep = rep; e.repne = repne;
        e.lock = lock; e.cnt = cnt; e.lat = lat; e.left = left;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        bus.fifo_empty   = (fifo_q.size() == 0);
        bus.fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic load(input logic [159:0] b, input int n);
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back(b[8*i +: 8]);
        refresh();
    endtask

    // Called just after a rising edge; the FIFO model pops on the edge
    // where fifo_rd_en was high.
    task automatic cycle();
        logic popped;
        #2;
        popped = bus.fifo_rd_en;
        @(posedge clk);
        #1;
        if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh();
    endtask

    task automatic check_flags(input string tag, input exp_t e);
        chk({tag, "_opcode"}, {24'h0, bus.opcode}, {24'h0, e.op});
        chk({tag, "_seg"},    {31'h0, bus.segment_override}, {31'h0, e.seg});
        chk({tag, "_sel"},    {30'h0, bus.segment_sel}, {30'h0, e.sel});
        chk({tag, "_rep"},    {31'h0, bus.rep}, {31'h0, e.rep});
        chk({tag, "_repne"},  {31'h0, bus.repne}, {31'h0, e.repne});
        chk({tag, "_lock"},   {31'h0, bus.lock}, {31'h0, e.lock});
        chk({tag, "_count"},  {28'h0, bus.prefix_count}, {28'h0, e.cnt});
    endtask

    task automatic wait_valid(input string tag);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!bus.opcode_valid && cyc < 200) begin
            cycle();
            cyc++;
        end
        if (!bus.opcode_valid || sb.size() == 0) begin
            chk({tag, "_valid_timeout"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_flags(tag, e);
            chk({tag, "_latency"}, cyc, e.lat);
            chk({tag, "_fifo_left"}, fifo_q.size(), e.left);
        end
    endtask

    task automatic accept_and_retire(input string tag, input logic [3:0] cnt);
        bus.opcode_ready = 1'b1;
        cycle();
        bus.opcode_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'h0, bus.opcode_valid}, 32'd0);
        chk({tag, "_exec_hold"}, {28'h0, bus.prefix_count}, {28'h0, cnt});
        fifo_q.delete();
        refresh();
        bus.next_instruction = 1'b1;
        cycle();
        bus.next_instruction = 1'b0;
        chk({tag, "_clr_count"}, {28'h0, bus.prefix_count}, 32'd0);
        chk({tag, "_clr_flags"},
            {28'h0, bus.segment_override, bus.rep, bus.repne, bus.lock}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [159:0] sat;
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.next_instruction = 1'b0;
        bus.opcode_ready = 1'b0;
        refresh();

        sat = '0;
        for (int i = 0; i < 17; i++) sat[8*i +: 8] = 8'h36;
        sat[8*17 +: 8] = 8'h90;

        // Byte 0 of each stream sits in the least significant byte.
        vecs[0] = '{{152'h0, 8'h8B}, 1, mk(8'h8B, 0, 0, 0, 0, 0, 0, 1, 0)};
        vecs[1] = '{{136'h0, 8'h8B, 8'h3E, 8'h26}, 3, mk(8'h8B, 1, 3, 0, 0, 0, 2, 3, 0)};
        vecs[2] = '{{136'h0, 8'hA4, 8'hF3, 8'hF2}, 3, mk(8'hA4, 0, 0, 1, 0, 0, 2, 3, 0)};
        vecs[3] = '{{136'h0, 8'hAC, 8'hF2, 8'hF3}, 3, mk(8'hAC, 0, 0, 0, 1, 0, 2, 3, 0)};
        vecs[4] = '{sat, 18, mk(8'h90, 1, 2, 0, 0, 0, 15, 18, 0)};
        vecs[5] = '{{128'h0, 8'h0F, 8'h26, 8'hF3, 8'h2E}, 4, mk(8'h0F, 1, 0, 1, 0, 0, 3, 4, 0)};
`ifdef LOCK_PREFIX_EN
        vecs[6] = '{{144'h0, 8'h90, 8'hF0}, 2, mk(8'h90, 0, 0, 0, 0, 1, 1, 2, 0)};
`else
        vecs[6] = '{{144'h0, 8'h90, 8'hF0}, 2, mk(8'hF0, 0, 0, 0, 0, 0, 0, 1, 1)};
`endif

        repeat (2) @(posedge clk);
        #1;
        check_flags("reset", mk(8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("reset_valid", {31'h0, bus.opcode_valid}, 32'd0);
        chk("reset_rd_en_empty", {31'h0, bus.fifo_rd_en}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        load({152'h0, 8'h8B}, 1);
        #1;
        chk("rd_en_nonempty", {31'h0, bus.fifo_rd_en}, 32'd1);
        fifo_q.delete();
        refresh();

        for (int i = 0; i < 7; i++) begin
            load(vecs[i].bytes, vecs[i].n);
            sb.push_back(vecs[i].e);
            wait_valid($sformatf("vec%0d", i));
            accept_and_retire($sformatf("vec%0d", i), vecs[i].e.cnt);
        end

        // Sequencer stall: opcode held, no pops, next_instruction ignored.
        load({128'h0, 8'h90, 8'hA4, 8'hF3, 8'hF2}, 4);
        sb.push_back(mk(8'hA4, 0, 0, 1, 0, 0, 2, 3, 1));
        wait_valid("stall");
        for (int k = 0; k < 5; k++) begin
            bus.next_instruction = (k == 2);
            #1;
            chk("stall_rd_en", {31'h0, bus.fifo_rd_en}, 32'd0);
            cycle();
            chk("stall_valid", {31'h0, bus.opcode_valid}, 32'd1);
            chk("stall_opcode", {24'h0, bus.opcode}, 32'hA4);
            chk("stall_fifo", fifo_q.size(), 1);
        end
        bus.next_instruction = 1'b0;
        chk("stall_rep", {30'h0, bus.rep, bus.repne}, 32'd2);
        accept_and_retire("stall", 4'd2);

        // Flush mid-prefix with F3 at the head.
        load({136'h0, 8'h8B, 8'hF3, 8'h2E}, 3);
        cycle();
        chk("flush_pre_seg", {31'h0, bus.segment_override}, 32'd1);
        chk("flush_pre_count", {28'h0, bus.prefix_count}, 32'd1);
        bus.flush = 1'b1;
        #1;
        chk("flush_rd_en", {31'h0, bus.fifo_rd_en}, 32'd0);
        cycle();
        bus.flush = 1'b0;
        chk("flush_seg_clr", {31'h0, bus.segment_override}, 32'd0);
        chk("flush_count_clr", {28'h0, bus.prefix_count}, 32'd0);
        chk("flush_fifo", fifo_q.size(), 2);
        #1;
        chk("flush_rd_en_after", {31'h0, bus.fifo_rd_en}, 32'd1);
        sb.push_back(mk(8'h8B, 0, 0, 1, 0, 0, 1, 2, 0));
        wait_valid("flush");

        // Flush while presenting drops opcode_valid.
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        chk("flush_present_valid", {31'h0, bus.opcode_valid}, 32'd0);
        chk("flush_present_rep", {31'h0, bus.rep}, 32'd0);

        // Back-to-back: pop allowed the cycle after next_instruction.
        load({144'h0, 8'h90, 8'h8B}, 2);
        sb.push_back(mk(8'h8B, 0, 0, 0, 0, 0, 0, 1, 1));
        wait_valid("b2b_first");
        bus.opcode_ready = 1'b1;
        cycle();
        bus.opcode_ready = 1'b0;
        bus.next_instruction = 1'b1;
        #1;
        chk("b2b_exec_rd_en", {31'h0, bus.fifo_rd_en}, 32'd0);
        cycle();
        bus.next_instruction = 1'b0;
        #1;
        chk("b2b_fetch_rd_en", {31'h0, bus.fifo_rd_en}, 32'd1);
        sb.push_back(mk(8'h90, 0, 0, 0, 0, 0, 0, 1, 0));
        wait_valid("b2b_second");
        accept_and_retire("b2b", 4'd0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
